// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and address-width helper for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } rf_state_e;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_NUM_REGS = 32;

    function automatic int addr_width(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write bit per register with flush > issue > writeback priority
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int AW       = addr_width(NUM_REGS)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       active_i,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]  wr_addr_i,
    input  logic                       issue_en_i,
    input  logic [AW-1:0]              issue_addr_i,
    input  logic                       flush_i,
    input  logic [NUM_RD-1:0][AW-1:0]  rd_addr_i,
    output logic [NUM_RD-1:0]          busy_o
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Issue is applied after writeback so a same-cycle re-issue keeps the bit set.
    always_comb begin
        pending_nxt = pending;
        if (flush_i) begin
            pending_nxt = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w]) begin
                    pending_nxt[wr_addr_i[w]] = 1'b0;
                end
            end
            if (issue_en_i && issue_addr_i != '0) begin
                pending_nxt[issue_addr_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending <= '0;
        end else if (active_i) begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            busy_o[p] = pending[rd_addr_i[p]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with sequential clear; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int AW       = addr_width(NUM_REGS)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    output logic                         init_done_o,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]    wr_addr_i,
    input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data_i,
    input  logic [NUM_RD-1:0][AW-1:0]    rd_addr_i,
    output logic [NUM_RD-1:0][XLEN-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]            rd_busy_o,
    input  logic                         issue_en_i,
    input  logic [AW-1:0]                issue_addr_i,
    input  logic                         flush_i
);

    rf_state_e       state;
    rf_state_e       state_nxt;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] regs [NUM_REGS];
    logic            ready;
    logic [NUM_RD-1:0] sb_busy;
    logic [NUM_RD-1:0] byp_hit;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + AW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == AW'(NUM_REGS - 1)) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    assign ready       = (state == READY);
    assign init_done_o = ready;

    // Storage has no reset of its own; the CLEAR walk zeroes one entry per cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (!ready) begin
                regs[clr_idx] <= '0;
            end else begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en_i[w] && wr_addr_i[w] != '0) begin
                        regs[wr_addr_i[w]] <= wr_data_i[w];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_o[p] = '0;
            byp_hit[p]   = 1'b0;
            if (ready && rd_addr_i[p] != '0) begin
                rd_data_o[p] = regs[rd_addr_i[p]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en_i[w] && wr_addr_i[w] == rd_addr_i[p]) begin
                        rd_data_o[p] = wr_data_i[w];
                        byp_hit[p]   = 1'b1;
                    end
                end
`endif
            end
        end
    end

    assign rd_busy_o = ready ? (sb_busy & ~byp_hit) : '0;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .AW       (AW)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .active_i     (ready),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .rd_addr_i    (rd_addr_i),
        .busy_o       (sb_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp against a behavioural model
module tb_regfile_mp;

    localparam int AW = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 init_done;
    logic [1:0]           wr_en;
    logic [1:0][AW-1:0]   wr_addr;
    logic [1:0][31:0]     wr_data;
    logic [1:0][AW-1:0]   rd_addr;
    logic [1:0][31:0]     rd_data;
    logic [1:0]           rd_busy;
    logic                 issue_en;
    logic [AW-1:0]        issue_addr;
    logic                 flush;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_ready;
    int          m_cnt;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .init_done_o  (init_done),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .flush_i      (flush)
    );

    // Architectural effect of one clock edge given the inputs currently applied.
    function automatic void model_edge();
        if (reset) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else if (!m_ready) begin
            m_regs[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 32) m_ready = 1'b1;
        end else begin
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w] != 0) m_regs[wr_addr[w]] = wr_data[w];
            if (flush) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
            end else begin
                for (int w = 0; w < 2; w++)
                    if (wr_en[w]) m_pend[wr_addr[w]] = 1'b0;
                if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] exp_data(input int p);
        int a = int'(rd_addr[p]);
        if (!m_ready || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        for (int w = 1; w >= 0; w--)
            if (wr_en[w] && int'(wr_addr[w]) == a) return wr_data[w];
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int p);
        int a = int'(rd_addr[p]);
        if (!m_ready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < 2; w++)
            if (wr_en[w] && int'(wr_addr[w]) == a) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        wr_addr = '0; wr_data = '0; rd_addr = '0; issue_addr = '0;
        repeat (3) step();
        rd_addr[0] = 5'd1; rd_addr[1] = 5'd3;
        #1;
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%b want=0", init_done); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_rd_busy got=%b want=00", rd_busy); end
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            if (e >= 20 && e <= 31) begin
                wr_en = 2'b11; wr_addr[0] = 5'd3; wr_addr[1] = 5'd2;
                wr_data[0] = $urandom(); wr_data[1] = $urandom();
                issue_en = 1'b1; issue_addr = 5'd6; flush = 1'b0;
            end
            rd_addr[0] = 5'($urandom_range(0, 31)); rd_addr[1] = 5'd3;
            #1;
            total++; if (rd_data !== '0 || rd_busy !== 2'b00) begin
                bad++; $display("FAIL clear_reads edge=%0d got=%h/%b want=0/00", e, rd_data, rd_busy);
            end
            step();
            total++; if (init_done !== (e == 32)) begin
                bad++; $display("FAIL init_done edge=%0d got=%b want=%b", e, init_done, e == 32);
            end
        end
        idle();
        rd_addr[0] = 5'd2; rd_addr[1] = 5'd6;
        #1;
        total++; if (rd_data[0] !== 32'h0) begin bad++; $display("FAIL clear_write_lost got=%h want=0", rd_data[0]); end
        total++; if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL clear_issue_lost got=%b want=0", rd_busy[1]); end
        rd_addr[0] = 5'd3;
        #1;
        total++; if (rd_data[0] !== 32'h0) begin bad++; $display("FAIL clear_write_lost3 got=%h want=0", rd_data[0]); end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        rd_addr[1] = 5'd5;
        step();
        idle();
        #1;
        total++; if (rd_data[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL write_read got=%h want=deadbeef", rd_data[1]); end
        wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h1234;
        issue_en = 1'b1; issue_addr = 5'd0;
        step();
        idle();
        rd_addr[0] = 5'd0;
        #1;
        total++; if (rd_data[0] !== 32'h0) begin bad++; $display("FAIL reg0_read got=%h want=0", rd_data[0]); end
        total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL reg0_busy got=%b want=0", rd_busy[0]); end
    endtask

    task automatic test_conflict();
        idle();
        wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
        wr_data[0] = 32'h11; wr_data[1] = 32'h22;
        step();
        idle();
        rd_addr[0] = 5'd7;
        #1;
        total++; if (rd_data[0] !== 32'h22) begin bad++; $display("FAIL conflict got=%h want=22", rd_data[0]); end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_en = 1'b1; issue_addr = 5'd9;
        rd_addr[0] = 5'd9; rd_addr[1] = 5'd3;
        step();
        total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL issue_busy got=%b want=1", rd_busy[0]); end
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h99;
        issue_en = 1'b1; issue_addr = 5'd9;
        step();
        idle();
        #1;
        total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL reissue_busy got=%b want=1", rd_busy[0]); end
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd3;
        step();
        idle();
        #1;
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL flush_busy got=%b want=00", rd_busy); end
        issue_en = 1'b1; issue_addr = 5'd12;
        step();
        idle();
        wr_en = 2'b10; wr_addr[1] = 5'd12; wr_data[1] = 32'hC;
        step();
        idle();
        rd_addr[0] = 5'd12;
        #1;
        total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL writeback_clear got=%b want=0", rd_busy[0]); end
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h11110000;
        issue_en = 1'b1; issue_addr = 5'd4;
        step();
        idle();
        wr_en = 2'b10; wr_addr[1] = 5'd4; wr_data[1] = 32'hA5A5A5A5;
        rd_addr[0] = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        total++; if (rd_data[0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_data got=%h want=a5a5a5a5", rd_data[0]); end
        total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL bypass_busy got=%b want=0", rd_busy[0]); end
`else
        total++; if (rd_data[0] !== 32'h11110000) begin bad++; $display("FAIL nobypass_data got=%h want=11110000", rd_data[0]); end
        total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL nobypass_busy got=%b want=1", rd_busy[0]); end
`endif
        step();
        idle();
        #1;
        total++; if (rd_data[0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL after_write_data got=%h want=a5a5a5a5", rd_data[0]); end
        total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL after_write_busy got=%b want=0", rd_busy[0]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en      = 2'($urandom());
            wr_addr[0] = 5'($urandom_range(0, 7));
            wr_addr[1] = 5'($urandom_range(0, 7));
            wr_data[0] = $urandom();
            wr_data[1] = $urandom();
            rd_addr[0] = 5'($urandom_range(0, 7));
            rd_addr[1] = 5'($urandom_range(0, 7));
            issue_en   = ($urandom_range(0, 2) == 0);
            issue_addr = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            #1;
            for (int p = 0; p < 2; p++) begin
                total++; if (rd_data[p] !== exp_data(p)) begin
                    bad++; $display("FAIL rand_data cyc=%0d port=%0d got=%h want=%h", c, p, rd_data[p], exp_data(p));
                end
                total++; if (rd_busy[p] !== exp_busy(p)) begin
                    bad++; $display("FAIL rand_busy cyc=%0d port=%0d got=%b want=%b", c, p, rd_busy[p], exp_busy(p));
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int a = 1; a < 32; a++) begin
            wr_en = 2'b01; wr_addr[0] = 5'(a); wr_data[0] = $urandom() | 32'h1;
            issue_en = 1'b1; issue_addr = 5'(32 - a);
            step();
        end
        idle();
        reset = 1'b1;
        step();
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL midreset_init_done got=%b want=0", init_done); end
        reset = 1'b0;
        repeat (32) step();
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL reinit_done got=%b want=1", init_done); end
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = 5'(a); rd_addr[1] = 5'(31 - a);
            #1;
            total++; if (rd_data !== '0 || rd_busy !== 2'b00) begin
                bad++; $display("FAIL reinit_read addr=%0d got=%h/%b want=0/00", a, rd_data, rd_busy);
            end
        end
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_ready = 1'b0;
        m_cnt   = 0;
        test_reset();
        test_write_read();
        test_conflict();
        test_scoreboard();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the next-generation RISC-V core. It supports a configurable number of read and write ports and a per-register pending-write scoreboard for dual-issue and hazard detection. Contents are cleared by a sequential init state machine instead of a single-cycle bulk reset. It sits between decode (reads, issue marking) and writeback (writes, scoreboard release).

## Interface
- XLEN, 32, data width in bits
- NUM_REGS, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NUM_REGS)
- NUM_RD, 2, number of read ports (1–4)
- NUM_WR, 2, number of write ports (1–2)

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  synchronous, active-high reset
- init_done_o  out  1  high once the clear sequence has completed
- wr_en_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR×AW  per-port write address
- wr_data_i  in  NUM_WR×XLEN  per-port write data
- rd_addr_i  in  NUM_RD×AW  per-port read address
- rd_data_o  out  NUM_RD×XLEN  per-port read data, combinational
- rd_busy_o  out  NUM_RD  register at rd_addr_i has a pending write
- issue_en_i  in  1  mark issue_addr_i pending
- issue_addr_i  in  AW  destination register of the issuing instruction
- flush_i  in  1  clear all pending bits

## Operation
- FSM states: CLEAR, READY. reset_i forces CLEAR, clear index = 0, all pending bits = 0.
- CLEAR:
  - Write 0 to regs[index] each cycle and increment the index.
  - After index NUM_REGS-1 is written, go to READY.
  - Write ports, issue_en_i and flush_i are ignored.
  - rd_data_o = 0 and rd_busy_o = 0.
- READY: normal operation. READY persists until reset_i.
- Register 0 is hardwired:
  - Reads of address 0 return 0.
  - Writes to address 0 are dropped.
  - Issue to address 0 never sets a pending bit.
- Write conflict: if both ports write the same address in one cycle, port NUM_WR-1 wins.
- Scoreboard, per register, priority high to low:
  - flush_i clears all bits.
  - issue_en_i sets bit[issue_addr_i].
  - Any enabled write to an address clears its bit.
  - Simultaneous issue and writeback to the same address: the bit ends set.
- rd_busy_o[p] = pending[rd_addr_i[p]], subject to bypass rules below.
- Reset mid-operation: the next edge returns to CLEAR with index 0. Pending bits are cleared and the clear restarts from register 0.

## Timing
- Reset values: init_done_o = 0, rd_data_o = 0, rd_busy_o = 0.
- init_done_o rises on the NUM_REGS-th rising edge after the first edge with reset_i low. That is 32 cycles at default.
- Writes: data is visible on the cycle after the write edge. Read latency is 0 (combinational from rd_addr_i).
- Issue/flush: the effect on rd_busy_o appears the cycle after the edge.
- Writeback clearing busy: visible the next cycle, or the same cycle with bypass (see Configuration).

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address matches an enabled write in the same cycle returns wr_data_i combinationally. The highest matching port wins.
  - rd_busy_o is 0 for that address.
  - Address 0 is still never bypassed.
- REGFILE_BYPASS_EN undefined:
  - Reads return the stored value and rd_busy_o reflects the registered pending bit.
  - Forwarding is the pipeline's responsibility.

## Structure
- regfile_pkg:
  - State enum {CLEAR, READY}.
  - Default localparams for XLEN/NUM_REGS.
  - Helper function computing AW.
- Sub-module regfile_scoreboard holds the pending-bit vector, issue/flush/writeback priority logic and rd_busy_o lookup. The regfile_mp top holds storage, the clear FSM, the read muxes and bypass.

## Test plan
- Reset for 3 cycles, then release → init_done_o stays 0 for 31 edges and is 1 on edge 32. All reads return 0 meanwhile. Writes issued during CLEAR are lost (read 0 after init).
- Write port 0 addr 5 = 0xDEADBEEF → read port 1 addr 5 returns 0xDEADBEEF next cycle. Write addr 0 = 0x1234 → reads 0.
- Both ports write addr 7 (0x11, 0x22) same cycle → read addr 7 = 0x22.
- Issue addr 9 → rd_busy_o = 1 next cycle. Writeback addr 9 while issuing addr 9 again → busy stays 1. Flush together with issue addr 3 → all busy bits 0 next cycle.
- Bypass: write addr 4 = 0xA5A5A5A5 while reading addr 4. With REGFILE_BYPASS_EN: same-cycle 0xA5A5A5A5 and busy 0. Without it: the old value that cycle, new value next.
- Assert reset_i mid-operation after filling regs → after re-init all regs read 0 and busy 0.
